hazard_mc: RTL and testbench

Parametrised successor to the pipeline hazard unit: generates forwarding selects, load-use and branch stalls, and adds a multi-cycle divider stall FSM, exception flush and a stall-cycle performance counter. Sits beside the 5-stage datapath, reading register indices and control bits from D/E/M/W and driving stall/flush enables of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_mc_div_stall_ctr.sv | 79 +++++++
 rtl/hazard_mc.sv | 133 +++++++++++++
 tb/tb_hazard_mc.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard unit and its divider stall FSM
package hazard_pkg;

    // E-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Divider occupancy FSM
    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/hazard_mc_div_stall_ctr.sv
// rtl/hazard_mc_div_stall_ctr.sv - multi-cycle divider occupancy FSM and countdown
module div_stall_ctr
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic stall,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    // The IDLE cycle in which the divide enters E is itself a stall cycle,
    // so BUSY only needs to cover the remaining DIV_CYCLES-1 stalls.
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;

    // State, countdown and registered busy/done; abort drops any run in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_state <= DIV_BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= (CNT_LOAD == '0);
                    end
                end
                DIV_BUSY: begin
                    // A second start while busy is the same divide still held in E
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - CNT_ONE;
                        r_done <= (r_cnt == CNT_ONE);
                    end else begin
                        r_state <= DIV_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the entry cycle plus every BUSY cycle before the final one
    always_comb begin
        stall = ((r_state == DIV_IDLE) && start) ||
                ((r_state == DIV_BUSY) && (r_cnt != '0));
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: rtl/hazard_mc.sv
// rtl/hazard_mc.sv - pipeline hazard unit: forwarding, stalls, flushes, divider hold, stall counter
module hazard_mc
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int DIV_CYCLES = 32,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   rsD,
    input  logic [RA_W-1:0]   rtD,
    input  logic [RA_W-1:0]   rsE,
    input  logic [RA_W-1:0]   rtE,
    input  logic [RA_W-1:0]   writeregE,
    input  logic [RA_W-1:0]   writeregM,
    input  logic [RA_W-1:0]   writeregW,
    input  logic              branchD,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              regwriteW,
    input  logic              divstartE,
    input  logic              excM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic              div_busy,
    output logic              div_done,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic              w_lwstall;
    logic              w_branchstall;
    logic              w_divstall;
    logic [PERF_W-1:0] r_stall_cycles;

    // A producer can only feed a consumer if it writes and the register is not r0
    function automatic logic reg_hit(input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] dst,
                                     input logic            we);
        return we && (src != '0) && (src == dst);
    endfunction

    // E operand bypass: the younger M result wins over W
    always_comb begin
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        if (reg_hit(rsE, writeregM, regwriteM))
            forwardaE = FWD_MEM;
        else if (reg_hit(rsE, writeregW, regwriteW))
            forwardaE = FWD_WB;
        if (reg_hit(rtE, writeregM, regwriteM))
            forwardbE = FWD_MEM;
        else if (reg_hit(rtE, writeregW, regwriteW))
            forwardbE = FWD_WB;
    end

    // D branch comparator bypass from M
    always_comb begin
        forwardaD = reg_hit(rsD, writeregM, regwriteM);
        forwardbD = reg_hit(rtD, writeregM, regwriteM);
    end

    // Load in E feeding D, and branch in D waiting on an E ALU result or M load
    always_comb begin
        w_lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
        w_branchstall = branchD &&
            ((regwriteE && (writeregE != '0) &&
              ((writeregE == rsD) || (writeregE == rtD))) ||
             (memtoregM && (writeregM != '0) &&
              ((writeregM == rsD) || (writeregM == rtD))));
    end

    div_stall_ctr #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (divstartE),
        .abort (excM),
        .stall (w_divstall),
        .busy  (div_busy),
        .done  (div_done)
    );

    // Pipeline control priority: exception, divider hold, load/branch bubble
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (w_divstall) begin
            // E is frozen, so the bubble goes into M instead of E
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (w_lwstall || w_branchstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (stallF && (r_stall_cycles != PERF_MAX))
            r_stall_cycles <= r_stall_cycles + PERF_ONE;
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_mc.sv
// tb/tb_hazard_mc.sv - self-checking bench for hazard_mc with a cycle-level reference model
module tb_hazard_mc;

    localparam int RA_W = 5;
    localparam int DIVC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [RA_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic            branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
    logic            divstartE, excM;

    logic        stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0]  forwardaE, forwardbE;
    logic        forwardaD, forwardbD, div_busy, div_done;
    logic [31:0] stall_cycles;

    logic        s_stallF, s_stallD, s_stallE, s_flushD, s_flushE, s_flushM;
    logic [1:0]  s_forwardaE, s_forwardbE;
    logic        s_forwardaD, s_forwardbD, s_div_busy, s_div_done;
    logic [2:0]  s_stall_cycles;

    hazard_mc #(.RA_W(RA_W), .DIV_CYCLES(DIVC), .PERF_W(32)) u_dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .regwriteW(regwriteW),
        .divstartE(divstartE), .excM(excM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .div_busy(div_busy), .div_done(div_done), .stall_cycles(stall_cycles)
    );

    hazard_mc #(.RA_W(RA_W), .DIV_CYCLES(DIVC), .PERF_W(3)) u_sat (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .regwriteW(regwriteW),
        .divstartE(divstartE), .excM(excM),
        .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE),
        .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
        .forwardaE(s_forwardaE), .forwardbE(s_forwardbE),
        .forwardaD(s_forwardaD), .forwardbD(s_forwardbD),
        .div_busy(s_div_busy), .div_done(s_div_done), .stall_cycles(s_stall_cycles)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a divide is remembered by the cycle number it entered E
    longint m_cycle     = 0;
    longint m_div_start = -1;
    longint m_perf      = 0;
    int     m_perf3     = 0;

    logic        e_stallF, e_stallD, e_stallE, e_flushD, e_flushE, e_flushM;
    logic [1:0]  e_fwdaE, e_fwdbE;
    logic        e_fwdaD, e_fwdbD, e_busy, e_done;

    function automatic logic [1:0] ref_fwdE(input logic [RA_W-1:0] r);
        if (r != 0 && regwriteM && r == writeregM) return 2'd2;
        if (r != 0 && regwriteW && r == writeregW) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_eval();
        logic dstall, lw, br;
        e_busy  = (m_div_start >= 0);
        e_done  = e_busy && (m_cycle == m_div_start + DIVC);
        dstall  = (!e_busy && divstartE) || (e_busy && (m_cycle < m_div_start + DIVC));
        e_fwdaE = ref_fwdE(rsE);
        e_fwdbE = ref_fwdE(rtE);
        e_fwdaD = (rsD != 0) && regwriteM && (rsD == writeregM);
        e_fwdbD = (rtD != 0) && regwriteM && (rtD == writeregM);
        lw = memtoregE && rtE != 0 && (rsD == rtE || rtD == rtE);
        br = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        {e_stallF, e_stallD, e_stallE, e_flushD, e_flushE, e_flushM} = 6'b000000;
        if (excM)         {e_flushD, e_flushE, e_flushM} = 3'b111;
        else if (dstall)  {e_stallF, e_stallD, e_stallE, e_flushM} = 4'b1111;
        else if (lw || br) {e_stallF, e_stallD, e_flushE} = 3'b111;
    endtask

    task automatic tick();
        model_eval();
        if (rst) begin
            m_div_start = -1;
            m_perf      = 0;
            m_perf3     = 0;
        end else begin
            if (excM)                    m_div_start = -1;
            else if (!e_busy && divstartE) m_div_start = m_cycle;
            else if (e_done)             m_div_start = -1;
            if (e_stallF) begin
                if (m_perf < 64'hFFFF_FFFF) m_perf++;
                if (m_perf3 < 7) m_perf3++;
            end
        end
        m_cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; regwriteE = 0; memtoregE = 0;
        regwriteM = 0; memtoregM = 0; regwriteW = 0;
        divstartE = 0; excM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if ({div_busy, div_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_div got %b want 00", {div_busy, div_done});
        end
        tests_run++;
        if (stall_cycles !== 32'd0 || s_stall_cycles !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", stall_cycles, s_stall_cycles);
        end
        tests_run++;
        if ({stallF, stallD, stallE, flushD, flushE, flushM} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl got %b want 000000", {stallF, stallD, stallE, flushD, flushE, flushM});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        @(negedge clk);
        tests_run++;
        if ({forwardaE, forwardbE} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL fwd_mem got %b want 1010", {forwardaE, forwardbE});
        end
        tick();
        rsE = 0;
        @(negedge clk);
        tests_run++;
        if ({forwardaE, forwardbE} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fwd_r0 got %b want 0010", {forwardaE, forwardbE});
        end
        tick();
        rsE = 3; regwriteM = 0;
        @(negedge clk);
        tests_run++;
        if ({forwardaE, forwardbE} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL fwd_wb got %b want 0101", {forwardaE, forwardbE});
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        memtoregE = 1; rtE = 5; rsD = 5;
        @(negedge clk);
        tests_run++;
        if ({stallF, stallD, stallE, flushE, flushM} !== 5'b11010) begin
            tests_failed++;
            $display("FAIL lw_rs got %b want 11010", {stallF, stallD, stallE, flushE, flushM});
        end
        tick();
        rsD = 0; rtD = 5;
        @(negedge clk);
        tests_run++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            tests_failed++;
            $display("FAIL lw_rt got %b want 111", {stallF, stallD, flushE});
        end
        tick();
        rtE = 0; rsD = 0; rtD = 0;
        @(negedge clk);
        tests_run++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            tests_failed++;
            $display("FAIL lw_r0 got %b want 000", {stallF, stallD, flushE});
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
        @(negedge clk);
        tests_run++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            tests_failed++;
            $display("FAIL br_alu got %b want 111", {stallF, stallD, flushE});
        end
        tick();
        regwriteE = 0; memtoregM = 1; writeregM = 7;
        @(negedge clk);
        tests_run++;
        if ({stallF, stallD, flushE} !== 3'b111) begin
            tests_failed++;
            $display("FAIL br_load got %b want 111", {stallF, stallD, flushE});
        end
        tick();
        memtoregM = 0; regwriteM = 1;
        @(negedge clk);
        tests_run++;
        if ({forwardbD, forwardaD, stallF} !== 3'b100) begin
            tests_failed++;
            $display("FAIL br_fwd got %b want 100", {forwardbD, forwardaD, stallF});
        end
        tick();
    endtask

    task automatic test_divider();
        do_reset();
        divstartE = 1;
        for (int i = 0; i < DIVC + 1; i++) begin
            @(negedge clk);
            tests_run++;
            if ({stallE, flushM, flushE, div_done} !== {(i < DIVC), (i < DIVC), 1'b0, (i == DIVC)}) begin
                tests_failed++;
                $display("FAIL div_cycle%0d got %b want %b", i, {stallE, flushM, flushE, div_done},
                         {(i < DIVC), (i < DIVC), 1'b0, (i == DIVC)});
            end
            tick();
        end
        divstartE = 0;
        @(negedge clk);
        tests_run++;
        if (stall_cycles !== 32'd4 || div_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_count got %0d busy %b want 4 busy 0", stall_cycles, div_busy);
        end
        tick();
    endtask

    task automatic test_exception();
        do_reset();
        divstartE = 1;
        tick();
        excM = 1;
        @(negedge clk);
        tests_run++;
        if ({flushD, flushE, flushM, stallF, stallD, stallE} !== 6'b111000) begin
            tests_failed++;
            $display("FAIL exc_ctl got %b want 111000", {flushD, flushE, flushM, stallF, stallD, stallE});
        end
        tick();
        excM = 0; divstartE = 0;
        for (int i = 0; i < DIVC + 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({div_busy, div_done} !== 2'b00) begin
                tests_failed++;
                $display("FAIL exc_after%0d got %b want 00", i, {div_busy, div_done});
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_div();
        do_reset();
        divstartE = 1;
        for (int i = 0; i < DIVC + 1; i++) tick();
        clear_inputs();
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 3; i++) tick();
        clear_inputs();
        divstartE = 1;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (stall_cycles !== 32'd9) begin
            tests_failed++;
            $display("FAIL pre_rst_count got %0d want 9", stall_cycles);
        end
        tests_run++;
        if (s_stall_cycles !== 3'd7) begin
            tests_failed++;
            $display("FAIL sat_count got %0d want 7", s_stall_cycles);
        end
        rst = 1; excM = 1;
        tick();
        rst = 0; excM = 0; divstartE = 0;
        @(negedge clk);
        tests_run++;
        if ({div_busy, div_done, stall_cycles, s_stall_cycles} !== 37'd0) begin
            tests_failed++;
            $display("FAIL rst_mid got busy %b done %b cnt %0d sat %0d want all 0",
                     div_busy, div_done, stall_cycles, s_stall_cycles);
        end
        tick();
    endtask

    task automatic test_random();
        logic [13:0] got, want;
        int errs = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rsD = RA_W'($urandom_range(0, 3));  rtD = RA_W'($urandom_range(0, 3));
            rsE = RA_W'($urandom_range(0, 3));  rtE = RA_W'($urandom_range(0, 3));
            writeregE = RA_W'($urandom_range(0, 3));
            writeregM = RA_W'($urandom_range(0, 3));
            writeregW = RA_W'($urandom_range(0, 3));
            {branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW} = 6'($urandom);
            divstartE = ($urandom_range(0, 5) == 0);
            excM      = ($urandom_range(0, 23) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            model_eval();
            got  = {stallF, stallD, stallE, flushD, flushE, flushM, forwardaE, forwardbE,
                    forwardaD, forwardbD, div_busy, div_done};
            want = {e_stallF, e_stallD, e_stallE, e_flushD, e_flushE, e_flushM, e_fwdaE, e_fwdbE,
                    e_fwdaD, e_fwdbD, e_busy, e_done};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                if (errs++ < 10) $display("FAIL rand_ctl cyc %0d got %h want %h", n, got, want);
            end
            tests_run++;
            if (stall_cycles !== 32'(m_perf) || s_stall_cycles !== 3'(m_perf3)) begin
                tests_failed++;
                if (errs++ < 10) $display("FAIL rand_perf cyc %0d got %0d/%0d want %0d/%0d",
                                          n, stall_cycles, s_stall_cycles, m_perf, m_perf3);
            end
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_divider();
        test_exception();
        test_rst_mid_div();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
